// File: rtl/input_event_arbiter.sv
// Input event arbiter: turns rising edges on the button/clap request lines into
// one-at-a-time commands over a valid/ready handshake. Urgent requesters win
// outright, the rest share the path round-robin, and every accepted command is
// followed by a programmable hold-off gap. Drops of already-pending requests
// are counted in a saturating counter.

// Per-requester lane: edge detect plus the pending bit.
module iea_req_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic acc_i,   // this requester's command is accepted this cycle
  output logic pend_o,
  output logic drop_o   // edge arrived while already pending and not accepted
);
  logic req_q, pend_q, edge_w;

  assign edge_w = req_i & ~req_q;
  assign drop_o = edge_w & pend_q & ~acc_i;
  assign pend_o = pend_q;

  // Edge register and pending bit; an edge in the accept cycle re-pends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      req_q  <= req_i;
      pend_q <= edge_w | (pend_q & ~acc_i);
    end
  end
endmodule

module input_event_arbiter #(
  parameter int               N_REQ       = 6,
  parameter int               ID_W        = 3,
  parameter int               HOLDOFF     = 1_000_000,
  parameter int               CNT_W       = 8,
  parameter logic [N_REQ-1:0] URGENT_MASK = 6'b000010
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_REQ-1:0]  req_i,
  input  logic              cmd_ready_i,
  output logic              cmd_valid_o,
  output logic [ID_W-1:0]   cmd_id_o,
  output logic [N_REQ-1:0]  cmd_onehot_o,
  output logic [N_REQ-1:0]  pend_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_e;

  state_e           state_q;
  logic             valid_q, busy_q, urg_q;
  logic [ID_W-1:0]  id_q, ptr_q;
  logic [HCW-1:0]   hold_q;
  logic [CNT_W-1:0] drop_q;

  logic [N_REQ-1:0] pend, drop_w, acc_vec;
  logic             acc;
  logic [ID_W-1:0]  win_id_d;
  logic             win_urg_d, found;
  int               idx;

  assign acc = (state_q == OFFER) & cmd_ready_i;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    assign acc_vec[k] = acc & (id_q == ID_W'(k));
    iea_req_lane u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (req_i[k]),
      .acc_i  (acc_vec[k]),
      .pend_o (pend[k]),
      .drop_o (drop_w[k])
    );
  end

  // Winner: lowest pending urgent index, else first pending at/after ptr (wrapping).
  always_comb begin
    win_id_d  = '0;
    found     = 1'b0;
    idx       = 0;
    win_urg_d = |(pend & URGENT_MASK);
    if (win_urg_d) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && pend[k] && URGENT_MASK[k]) begin
          win_id_d = ID_W'(k);
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(ptr_q) + i) % N_REQ;
        if (!found && pend[idx]) begin
          win_id_d = ID_W'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  // Offer FSM with registered outputs; the offer is frozen until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      urg_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pend) begin
            id_q    <= win_id_d;
            urg_q   <= win_urg_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready_i) begin
            valid_q <= 1'b0;
            // Urgent grants must not disturb the round-robin position.
            if (!urg_q)
              ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            if (HOLDOFF == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              hold_q  <= HOLD_LOAD;
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating drop counter; any number of drops in one cycle adds one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_q <= '0;
    else if (|drop_w && drop_q != {CNT_W{1'b1}})
      drop_q <= drop_q + 1'b1;
  end

  assign cmd_valid_o  = valid_q;
  assign cmd_id_o     = id_q;
  assign cmd_onehot_o = valid_q ? (N_REQ'(1) << id_q) : '0;
  assign pend_o       = pend;
  assign busy_o       = busy_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Directed bench for input_event_arbiter with HOLDOFF=4, CNT_W=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_input_event_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] req = '0;
  logic       ready = 1'b0;
  logic       valid, busy;
  logic [2:0] id;
  logic [5:0] onehot, pend;
  logic [3:0] drop;

  int nvec = 0;
  int nfail = 0;

  input_event_arbiter #(
    .N_REQ(6), .ID_W(3), .HOLDOFF(4), .CNT_W(4), .URGENT_MASK(6'b000010)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .cmd_ready_i  (ready),
    .cmd_valid_o  (valid),
    .cmd_id_o     (id),
    .cmd_onehot_o (onehot),
    .pend_o       (pend),
    .busy_o       (busy),
    .drop_cnt_o   (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] m);
    @(negedge clk); req = m;
    @(negedge clk); req = '0;
  endtask

  // Wait (bounded) for the next offer, then check its id; cyc = negedges waited.
  task automatic wait_grant(input string tag, input int exp_id, output int cyc);
    logic [5:0] oh;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (valid) break;
    end
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_id"}, id, exp_id);
    oh = 6'(1 << exp_id);
    chk({tag, "_onehot"}, onehot, oh);
  endtask

  initial begin
    int  c;
    bit  seen;

    // Reset state
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_id", id, 0);
    chk("rst_onehot", onehot, 0);
    chk("rst_pend", pend, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);

    // 1: single pulse on idx 2, latency and hold-off
    ready = 1'b1;
    @(negedge clk); req = 6'b000100;
    @(negedge clk); req = '0;
    chk("t1_valid_early", valid, 0);
    chk("t1_pend", pend, 6'h04);
    @(negedge clk);
    chk("t1_valid", valid, 1);
    chk("t1_id", id, 2);
    chk("t1_onehot", onehot, 6'h04);
    chk("t1_busy_offer", busy, 1);
    @(negedge clk);
    chk("t1_valid_drop", valid, 0);
    chk("t1_pend_clr", pend, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_busy_hold", busy, 1);
      @(negedge clk);
    end
    chk("t1_busy_idle", busy, 0);

    // 2: round-robin from ptr=0 after reset
    do_reset();
    ready = 1'b1;
    pulse(6'b101001);
    wait_grant("t2_g0", 0, c);
    wait_grant("t2_g3", 3, c);
    chk("t2_gap3", c, 6);
    wait_grant("t2_g5", 5, c);
    chk("t2_gap5", c, 6);
    pulse(6'b100001);
    wait_grant("t2_g0b", 0, c);
    wait_grant("t2_g5b", 5, c);

    // 3: urgent first, urgent grants leave ptr alone (ptr=0 here)
    pulse(6'b010010);
    wait_grant("t3_g1", 1, c);
    wait_grant("t3_g4", 4, c);           // ptr -> 5
    pulse(6'b000010);
    wait_grant("t3_g1b", 1, c);          // ptr stays 5
    pulse(6'b001001);
    wait_grant("t3_g0", 0, c);           // from ptr 5 -> 0 before 3
    wait_grant("t3_g3", 3, c);

    // 4: stalled offer is not preempted by an urgent request
    ready = 1'b0;
    pulse(6'b001000);
    wait_grant("t4_g3", 3, c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req = (i == 0) ? 6'b000010 : 6'b000000;
      chk("t4_hold_valid", valid, 1);
      chk("t4_hold_id", id, 3);
    end
    ready = 1'b1;
    wait_grant("t4_g1", 1, c);
    chk("t4_gap", c, 6);

    // 5: drops while pending, multi-drop cycle, re-pend on accept, saturation
    do_reset();
    pulse(6'b001101);
    wait_grant("t5_g0", 0, c);
    chk("t5_drop0", drop, 0);
    repeat (3) pulse(6'b000100);
    chk("t5_drop3", drop, 3);
    chk("t5_still_id", id, 0);
    pulse(6'b001100);
    chk("t5_drop_multi", drop, 4);
    @(negedge clk); req = 6'b000001; ready = 1'b1;
    @(negedge clk); req = '0; ready = 1'b0;
    chk("t5_repend", pend, 6'h0D);
    chk("t5_repend_drop", drop, 4);
    chk("t5_acc_valid", valid, 0);
    repeat (16) pulse(6'b000100);
    chk("t5_drop_sat", drop, 15);
    chk("t5_offer_valid", valid, 1);
    chk("t5_offer_id", id, 2);

    // 6: asynchronous reset mid-offer
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", valid, 0);
    chk("t6_id", id, 0);
    chk("t6_onehot", onehot, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pend", pend, 0);
    chk("t6_drop", drop, 0);
    @(negedge clk); rst = 1'b0; ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | valid | (|pend);
    end
    chk("t6_lost", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
